// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I memory stage. Holds the EX/MEM pipeline register and a
// load/store unit that talks to a variable-latency data memory over a req/ack
// handshake.
//
// Ports:
//   clk, rst_n              clock and async active-low reset
//   *E_i                    execute-stage results and control, captured when not stalled
//   StallM_o                hold EX/MEM and everything upstream
//   *M_o                    registered results/control toward MEM/WB
//   ReadDataM_o             aligned, extended load data (valid in the ack cycle)
//   MisalignM_o, BusErrM_o  misaligned access / request timed out
//   mem_*                   data memory request channel

module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ValidE_i,
  input  logic [31:0] ALUResultE_i,
  input  logic [31:0] WriteDataE_i,
  input  logic        MemReadE_i,
  input  logic        MemWriteE_i,
  input  logic [2:0]  Funct3E_i,
  input  logic        RegWriteE_i,
  input  logic [1:0]  ResultSrcE_i,
  input  logic [4:0]  RdE_i,
  input  logic [31:0] PCPlus4E_i,
  output logic        StallM_o,
  output logic [31:0] ALUResultM_o,
  output logic [31:0] ReadDataM_o,
  output logic        RegWriteM_o,
  output logic [1:0]  ResultSrcM_o,
  output logic [4:0]  RdM_o,
  output logic [31:0] PCPlus4M_o,
  output logic        MisalignM_o,
  output logic        BusErrM_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b001, 3'b101: return off[0];
      3'b010:         return off != 2'b00;
      default:        return 1'b0;
    endcase
  endfunction

  // EX/MEM register
  logic        valid_q;
  logic [31:0] alu_q, wd_q, pc4_q;
  logic        rd_en_q, wr_en_q, regw_q;
  logic [2:0]  f3_q;
  logic [1:0]  rsrc_q;
  logic [4:0]  rd_q;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              memop_e, timeout, stall, misalign_m;

  // The op about to be captured decides whether M starts out busy, so the request
  // is up in the very first M cycle yet still comes from a flop.
  assign memop_e = ValidE_i & (MemReadE_i | MemWriteE_i) &
                   ~misaligned(Funct3E_i, ALUResultE_i[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      wd_q    <= '0;
      pc4_q   <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      regw_q  <= 1'b0;
      f3_q    <= '0;
      rsrc_q  <= '0;
      rd_q    <= '0;
    end else if (!stall) begin
      valid_q <= ValidE_i;
      alu_q   <= ALUResultE_i;
      wd_q    <= WriteDataE_i;
      pc4_q   <= PCPlus4E_i;
      rd_en_q <= MemReadE_i;
      wr_en_q <= MemWriteE_i;
      regw_q  <= RegWriteE_i;
      f3_q    <= Funct3E_i;
      rsrc_q  <= ResultSrcE_i;
      rd_q    <= RdE_i;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // FSM next state: leaving M (ack, timeout or non-memory op) always captures the
  // next op, which re-enters BUSY at once when it is a memory op.
  always_comb begin
    state_d = state_q;
    count_d = '0;
    if (stall) begin
      count_d = count_q + 1'b1;
    end else begin
      state_d = memop_e ? StBusy : StIdle;
    end
  end

  // FSM outputs
  always_comb begin
    mem_req_o = (state_q == StBusy);
    timeout   = mem_req_o & (count_q == CntMax) & ~mem_ack_i;
    stall     = mem_req_o & ~mem_ack_i & ~timeout;
  end

  assign StallM_o     = stall;
  assign BusErrM_o    = timeout;
  assign misalign_m   = valid_q & (rd_en_q | wr_en_q) & misaligned(f3_q, alu_q[1:0]);
  assign MisalignM_o  = misalign_m;
  assign RegWriteM_o  = valid_q & regw_q & ~misalign_m & ~timeout;
  assign ALUResultM_o = alu_q;
  assign ResultSrcM_o = rsrc_q;
  assign RdM_o        = rd_q;
  assign PCPlus4M_o   = pc4_q;

  assign mem_we_o   = mem_req_o & wr_en_q;
  assign mem_addr_o = {alu_q[31:2], 2'b00};

  always_comb begin
    case (f3_q[1:0])
      2'b00:   mem_be_o = 4'b0001 << alu_q[1:0];
      2'b01:   mem_be_o = 4'b0011 << alu_q[1:0];
      default: mem_be_o = 4'b1111;
    endcase
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00:   mem_wdata_o = {4{wd_q[7:0]}};
      2'b01:   mem_wdata_o = {2{wd_q[15:0]}};
      default: mem_wdata_o = wd_q;
    endcase
  end

  logic [31:0] lane;
  assign lane = mem_rdata_i >> {alu_q[1:0], 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ReadDataM_o = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ReadDataM_o = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ReadDataM_o = {24'h0, lane[7:0]};
      3'b101:  ReadDataM_o = {16'h0, lane[15:0]};
      default: ReadDataM_o = mem_rdata_i;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int T = 16;

  logic        clk, rst_n;
  logic        ValidE_i, MemReadE_i, MemWriteE_i, RegWriteE_i;
  logic [31:0] ALUResultE_i, WriteDataE_i, PCPlus4E_i;
  logic [2:0]  Funct3E_i;
  logic [1:0]  ResultSrcE_i;
  logic [4:0]  RdE_i;
  logic        StallM_o, RegWriteM_o, MisalignM_o, BusErrM_o;
  logic [31:0] ALUResultM_o, ReadDataM_o, PCPlus4M_o;
  logic [1:0]  ResultSrcM_o;
  logic [4:0]  RdM_o;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .ValidE_i(ValidE_i), .ALUResultE_i(ALUResultE_i), .WriteDataE_i(WriteDataE_i),
    .MemReadE_i(MemReadE_i), .MemWriteE_i(MemWriteE_i), .Funct3E_i(Funct3E_i),
    .RegWriteE_i(RegWriteE_i), .ResultSrcE_i(ResultSrcE_i), .RdE_i(RdE_i),
    .PCPlus4E_i(PCPlus4E_i), .StallM_o(StallM_o), .ALUResultM_o(ALUResultM_o),
    .ReadDataM_o(ReadDataM_o), .RegWriteM_o(RegWriteM_o), .ResultSrcM_o(ResultSrcM_o),
    .RdM_o(RdM_o), .PCPlus4M_o(PCPlus4M_o), .MisalignM_o(MisalignM_o),
    .BusErrM_o(BusErrM_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction as seen by the memory stage, plus how the memory answers it
  // and optional hand-computed expectations at retirement.
  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wd;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic        regw;
    logic [1:0]  rsrc;
    logic [4:0]  rd;
    logic [31:0] pc4;
    int          lat;
    logic [31:0] rdata;
    logic        lit;
    logic [3:0]  l_be;
    logic [31:0] l_val;
    int          l_stalls;
    logic        l_regw;
    logic        l_mis;
    logic        l_berr;
  } op_t;

  op_t  op_q[$];
  op_t  m, e_cur;
  int   wt;
  logic pstall;
  logic last_memop;
  logic rnd_mode;
  int   total, bad;
  logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int sz(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic mis(input op_t o);
    int off;
    if (!(o.valid && (o.rd_en || o.wr_en))) return 1'b0;
    off = int'(o.alu[1:0]);
    return (sz(o.f3) == 2 && (off % 2) == 1) || (o.f3 == 3'b010 && off != 0);
  endfunction

  function automatic logic [3:0] ebe(input op_t o);
    logic [3:0] b;
    int off, s;
    off = int'(o.alu[1:0]);
    s = sz(o.f3);
    for (int i = 0; i < 4; i++) b[i] = (i >= off) && (i < off + s);
    return b;
  endfunction

  function automatic logic [31:0] ewd(input op_t o);
    logic [31:0] r;
    int s;
    s = sz(o.f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = o.wd[8*(i % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] eload(input op_t o);
    logic [31:0] v;
    int s;
    s = sz(o.f3);
    if (s == 4) return o.rdata;
    v = o.rdata >> (8 * int'(o.alu[1:0]));
    if (s == 1) begin
      v = v & 32'h0000_00FF;
      if (!o.f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'h0000_FFFF;
      if (!o.f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // ---------------- stimulus ----------------
  function automatic op_t mk(input logic r, input logic w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wdat,
                             input logic [31:0] rdat, input int lat, input logic regw);
    op_t o;
    o = '0;
    o.valid = 1'b1; o.rd_en = r; o.wr_en = w; o.f3 = f3; o.alu = a; o.wd = wdat;
    o.rdata = rdat; o.lat = lat; o.regw = regw; o.rsrc = 2'b01; o.rd = 5'd7;
    o.pc4 = a + 32'd4;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int k;
    o = '0;
    o.valid = ($urandom_range(0, 7) != 0);
    o.alu = $urandom; o.wd = $urandom; o.pc4 = $urandom; o.rdata = $urandom;
    o.rsrc = 2'($urandom_range(0, 3)); o.rd = 5'($urandom_range(0, 31));
    k = $urandom_range(0, 2);
    if (k == 0) begin
      o.f3 = 3'($urandom_range(0, 7)); o.regw = 1'($urandom_range(0, 1));
    end else if (k == 1) begin
      o.rd_en = 1'b1; o.f3 = ld_f3[$urandom_range(0, 4)]; o.regw = 1'b1;
    end else begin
      o.wr_en = 1'b1; o.f3 = 3'($urandom_range(0, 2));
    end
    o.lat = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
    return o;
  endfunction

  function automatic op_t next_op();
    op_t o;
    if (op_q.size() != 0) return op_q.pop_front();
    if (rnd_mode) return rand_op();
    o = '0;
    return o;
  endfunction

  task automatic drive_e(input op_t o);
    ValidE_i = o.valid; ALUResultE_i = o.alu; WriteDataE_i = o.wd;
    MemReadE_i = o.rd_en; MemWriteE_i = o.wr_en; Funct3E_i = o.f3;
    RegWriteE_i = o.regw; ResultSrcE_i = o.rsrc; RdE_i = o.rd; PCPlus4E_i = o.pc4;
  endtask

  // One clock: advance the model across the edge, drive, then compare mid-cycle.
  task automatic cycle();
    logic memop, ack, tmo, stl;
    @(posedge clk);
    if (!pstall) begin
      m = e_cur; wt = 0; e_cur = next_op();
    end else begin
      wt++;
    end
    #1;
    drive_e(e_cur);
    memop = m.valid && (m.rd_en || m.wr_en) && !mis(m);
    ack = memop ? (wt == m.lat) : ($urandom_range(0, 3) == 0);
    mem_ack_i = ack;
    mem_rdata_i = memop ? m.rdata : $urandom;
    #2;
    tmo = memop && (wt == T - 1) && !ack;
    stl = memop && !ack && !tmo;
    chk("stall", 32'(StallM_o), 32'(stl));
    chk("req", 32'(mem_req_o), 32'(memop));
    chk("misalign", 32'(MisalignM_o), 32'(mis(m)));
    chk("buserr", 32'(BusErrM_o), 32'(tmo));
    chk("regwrite", 32'(RegWriteM_o), 32'(m.valid && m.regw && !mis(m) && !tmo));
    chk("aluresult", ALUResultM_o, m.alu);
    chk("resultsrc", 32'(ResultSrcM_o), 32'(m.rsrc));
    chk("rd", 32'(RdM_o), 32'(m.rd));
    chk("pcplus4", PCPlus4M_o, m.pc4);
    if (memop) begin
      chk("we", 32'(mem_we_o), 32'(m.wr_en));
      chk("addr", mem_addr_o, {m.alu[31:2], 2'b00});
      chk("be", 32'(mem_be_o), 32'(ebe(m)));
      if (m.wr_en) chk("wdata", mem_wdata_o, ewd(m));
      if (ack && m.rd_en) chk("readdata", ReadDataM_o, eload(m));
    end
    if (m.lit && !stl) begin
      chk("lit_stalls", 32'(wt), 32'(m.l_stalls));
      chk("lit_regwrite", 32'(RegWriteM_o), 32'(m.l_regw));
      chk("lit_misalign", 32'(MisalignM_o), 32'(m.l_mis));
      chk("lit_buserr", 32'(BusErrM_o), 32'(m.l_berr));
      if (!m.l_mis && !m.l_berr && (m.rd_en || m.wr_en)) begin
        chk("lit_be", 32'(mem_be_o), 32'(m.l_be));
        if (m.rd_en) chk("lit_readdata", ReadDataM_o, m.l_val);
        if (m.wr_en) chk("lit_wdata", mem_wdata_o, m.l_val);
      end
    end
    last_memop = memop;
    pstall = stl;
  endtask

  task automatic push_lit(input op_t o, input logic [3:0] be, input logic [31:0] v,
                          input int st, input logic rw, input logic mi, input logic be_err);
    op_t x;
    x = o;
    x.lit = 1'b1; x.l_be = be; x.l_val = v; x.l_stalls = st;
    x.l_regw = rw; x.l_mis = mi; x.l_berr = be_err;
    op_q.push_back(x);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req"}, 32'(mem_req_o), 32'd0);
    chk({tag, "_stall"}, 32'(StallM_o), 32'd0);
    chk({tag, "_regwrite"}, 32'(RegWriteM_o), 32'd0);
    chk({tag, "_misalign"}, 32'(MisalignM_o), 32'd0);
    chk({tag, "_buserr"}, 32'(BusErrM_o), 32'd0);
    chk({tag, "_alu"}, ALUResultM_o, 32'd0);
    chk({tag, "_pc4"}, PCPlus4M_o, 32'd0);
    chk({tag, "_rd"}, 32'(RdM_o), 32'd0);
  endtask

  initial begin
    op_t z;
    logic hit;
    total = 0; bad = 0; wt = 0; pstall = 1'b0; rnd_mode = 1'b0; last_memop = 1'b0;
    z = '0;
    m = z;
    rst_n = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    drive_e(z);
    #2;
    check_zero("reset");

    push_lit(mk(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1),
             4'b1111, 32'hDEADBEEF, 0, 1, 0, 0);
    push_lit(mk(1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 3, 1),
             4'b1000, 32'hFFFFFF80, 3, 1, 0, 0);
    push_lit(mk(1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 3, 1),
             4'b1000, 32'h00000080, 3, 1, 0, 0);
    push_lit(mk(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 1, 0),
             4'b1100, 32'hABCDABCD, 1, 0, 0, 0);
    push_lit(mk(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1), 4'b0000, 32'h0, 0, 0, 1, 0);
    push_lit(mk(1, 0, 3'b010, 32'h104, 32'h0, 32'h1111, 40, 1), 4'b1111, 32'h0, 15, 0, 0, 1);
    push_lit(mk(1, 0, 3'b010, 32'h108, 32'h0, 32'h2222, 15, 1),
             4'b1111, 32'h2222, 15, 1, 0, 0);
    push_lit(mk(0, 0, 3'b001, 32'h333, 32'h0, 32'h0, 0, 1), 4'b0000, 32'h0, 0, 1, 0, 0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e_cur = next_op();
    drive_e(e_cur);

    for (int i = 0; i < 80; i++) cycle();
    rnd_mode = 1'b1;
    for (int i = 0; i < 1500; i++) cycle();
    rnd_mode = 1'b0;
    while (op_q.size() != 0) void'(op_q.pop_front());
    for (int i = 0; i < 30; i++) cycle();

    // Reset in the middle of an outstanding load.
    op_q.push_back(mk(1, 0, 3'b010, 32'h200, 32'h0, 32'h0, 40, 1));
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cycle();
      if (last_memop && m.alu == 32'h200 && wt == 4) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL reset_setup: got busy=0 want busy=1 at %0t", $time);
    end
    #1;
    rst_n = 1'b0;
    mem_ack_i = 1'b0;
    #1;
    check_zero("midreset");
    @(posedge clk);
    #1;
    check_zero("heldreset");
    rst_n = 1'b1;
    m = z; wt = 0; pstall = 1'b0;
    while (op_q.size() != 0) void'(op_q.pop_front());
    push_lit(mk(1, 0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 2, 1),
             4'b1111, 32'hCAFEF00D, 2, 1, 0, 0);
    e_cur = next_op();
    drive_e(e_cur);
    for (int i = 0; i < 10; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
